// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32 opcode / funct3 constants, immediate extractors and the
// decoded writeback-control bundle shared by the writeback/retire slice.
package rv32_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Decoded control for the instruction sitting in WB this cycle.
  typedef struct packed {
    logic        retire;
    logic        we;
    logic        redir;
    logic        dz_set;
    logic [31:0] target;
  } wb_ctl_t;

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/wb_retire_unit_if.sv
// wb_retire_unit_if: bundle between the MA/WB register + decode/PC-select
// (master) and the writeback/retire unit (slave).
//   wb_*            : instruction, PC, writeback data, MA branch compares, stall
//   rs1/rs2_addr    : decode read ports; rs1/rs2_data bypassed read data
//   redirect_*      : late branch / JAL redirect pulse and target
//   retire_*, minstret : retirement pulse, PC and count
//   dz_flag/dz_clr  : sticky divide-by-zero flag and its clear
interface wb_retire_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  logic [31:0]      wb_inst;
  logic [XLEN-1:0]  wb_pc;
  logic [XLEN-1:0]  wb_data;
  logic             wb_branch_neq;
  logic             wb_branch_lt;
  logic             wb_branch_rs2_eq_0;
  logic             wb_stall;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             retire_valid;
  logic [XLEN-1:0]  retire_pc;
  logic [CNT_W-1:0] minstret;
  logic             dz_flag;
  logic             dz_clr;

  modport master (
    output wb_inst, wb_pc, wb_data, wb_branch_neq, wb_branch_lt,
           wb_branch_rs2_eq_0, wb_stall, rs1_addr, rs2_addr, dz_clr,
    input  rs1_data, rs2_data, redirect_valid, redirect_pc, retire_valid,
           retire_pc, minstret, dz_flag
  );

  modport slave (
    input  wb_inst, wb_pc, wb_data, wb_branch_neq, wb_branch_lt,
           wb_branch_rs2_eq_0, wb_stall, rs1_addr, rs2_addr, dz_clr,
    output rs1_data, rs2_data, redirect_valid, redirect_pc, retire_valid,
           retire_pc, minstret, dz_flag
  );
endinterface

// File: rtl/rv32_regfile.sv
// rv32_regfile: 2-read / 1-write integer register file.
//   clk, reset        : posedge clock, async active-high reset (clears all regs)
//   we/waddr/wdata    : write port, posedge; writes to x0 are dropped
//   raddr1/2, rdata1/2: asynchronous reads; x0 always reads 0
module rv32_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);
  logic [XLEN-1:0] rf [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (we && waddr != '0) begin
      rf[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : rf[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : rf[raddr2];
endmodule

// File: rtl/wb_retire_unit.sv
// wb_retire_unit: writeback / retire stage.
//   clk, reset : posedge clock, async active-high reset
//   bus        : wb_retire_unit_if slave side -- WB instruction/pc/data and
//                MA branch compares in; bypassed register reads, redirect
//                pulse/target, retire pulse/pc, minstret and dz_flag out.
// Writes the register file, bypasses the WB write to decode reads, resolves
// late branches and JAL into a redirect, counts retirements.
module wb_retire_unit
  import rv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 64
) (
  input  logic            clk,
  input  logic            reset,
  wb_retire_unit_if.slave bus
);
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       wr_op;
  logic       br_taken;
  wb_ctl_t    ctl;

  logic [XLEN-1:0]  rf_rd1, rf_rd2;
  logic             redirect_valid_q, retire_valid_q, dz_q;
  logic [XLEN-1:0]  redirect_pc_q, retire_pc_q;
  logic [CNT_W-1:0] minstret_q;

  assign opcode = bus.wb_inst[6:0];
  assign rd     = bus.wb_inst[11:7];
  assign f3     = bus.wb_inst[14:12];
  assign f7     = bus.wb_inst[31:25];

  always_comb begin
    wr_op = 1'b0;
    case (opcode)
      OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR: wr_op = 1'b1;
      default:                                 wr_op = 1'b0;
    endcase
  end

  // MA already computed the compares (signedness picked by funct3 there).
  always_comb begin
    br_taken = 1'b0;
    case (f3)
      F3_BEQ:          br_taken = !bus.wb_branch_neq;
      F3_BNE:          br_taken =  bus.wb_branch_neq;
      F3_BLT, F3_BLTU: br_taken =  bus.wb_branch_lt;
      F3_BGE, F3_BGEU: br_taken = !bus.wb_branch_lt;
      default:         br_taken = 1'b0;
    endcase
  end

  // JALR is redirected by EX, so only taken branches and JAL redirect here.
  always_comb begin
    ctl        = '0;
    ctl.retire = !bus.wb_stall && (bus.wb_inst != 32'h0);
    ctl.we     = ctl.retire && (rd != 5'd0) && wr_op;
    ctl.redir  = ctl.retire && ((opcode == BRANCH && br_taken) || opcode == JAL);
    ctl.target = (opcode == JAL) ? (bus.wb_pc + imm_j(bus.wb_inst))
                                 : (bus.wb_pc + imm_b(bus.wb_inst));
    ctl.dz_set = ctl.retire && (opcode == OP) && (f7 == F7_MULDIV) && f3[2] &&
                 bus.wb_branch_rs2_eq_0;
  end

  rv32_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (ctl.we),
    .waddr  (rd),
    .wdata  (bus.wb_data),
    .raddr1 (bus.rs1_addr),
    .raddr2 (bus.rs2_addr),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  // ctl.we implies rd != 0, so a matching bypass can never hit x0.
  assign bus.rs1_data = (ctl.we && rd == bus.rs1_addr) ? bus.wb_data : rf_rd1;
  assign bus.rs2_data = (ctl.we && rd == bus.rs2_addr) ? bus.wb_data : rf_rd2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      retire_valid_q   <= 1'b0;
      retire_pc_q      <= '0;
      minstret_q       <= '0;
      dz_q             <= 1'b0;
    end else begin
      redirect_valid_q <= ctl.redir;
      retire_valid_q   <= ctl.retire;
      if (ctl.redir) redirect_pc_q <= ctl.target;
      if (ctl.retire) begin
        retire_pc_q <= bus.wb_pc;
        minstret_q  <= minstret_q + 1'b1;
      end
      // set has priority over a same-cycle clear
      if (ctl.dz_set)      dz_q <= 1'b1;
      else if (bus.dz_clr) dz_q <= 1'b0;
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.retire_valid   = retire_valid_q;
  assign bus.retire_pc      = retire_pc_q;
  assign bus.minstret       = minstret_q;
  assign bus.dz_flag        = dz_q;
endmodule

// File: tb/tb_wb_retire_unit.sv
module tb_wb_retire_unit;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  longint unsigned exp_ret = 0;

  wb_retire_unit_if #(.XLEN(32), .CNT_W(64)) ifc ();
  wb_retire_unit_if #(.XLEN(32), .CNT_W(4))  ifc_w ();

  wb_retire_unit #(.XLEN(32), .NREGS(32), .CNT_W(64)) dut (
    .clk(clk), .reset(reset), .bus(ifc));

  // narrow-counter copy sees the same stimulus; used to observe wrap-around
  wb_retire_unit #(.XLEN(32), .NREGS(32), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .bus(ifc_w));

  assign ifc_w.wb_inst            = ifc.wb_inst;
  assign ifc_w.wb_pc              = ifc.wb_pc;
  assign ifc_w.wb_data            = ifc.wb_data;
  assign ifc_w.wb_branch_neq      = ifc.wb_branch_neq;
  assign ifc_w.wb_branch_lt       = ifc.wb_branch_lt;
  assign ifc_w.wb_branch_rs2_eq_0 = ifc.wb_branch_rs2_eq_0;
  assign ifc_w.wb_stall           = ifc.wb_stall;
  assign ifc_w.rs1_addr           = ifc.rs1_addr;
  assign ifc_w.rs2_addr           = ifc.rs2_addr;
  assign ifc_w.dz_clr             = ifc.dz_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] data, input logic stall);
    ifc.wb_inst  = inst;
    ifc.wb_pc    = pc;
    ifc.wb_data  = data;
    ifc.wb_stall = stall;
  endtask

  task automatic flags(input logic neq, input logic lt, input logic z);
    ifc.wb_branch_neq      = neq;
    ifc.wb_branch_lt       = lt;
    ifc.wb_branch_rs2_eq_0 = z;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 1'b0);
    flags(1'b0, 1'b0, 1'b0);
    ifc.rs1_addr = 5'd5; ifc.rs2_addr = 5'd0; ifc.dz_clr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (ifc.retire_valid !== 1'b0) begin errors++; $display("FAIL rst_retire_valid got %0h exp 0", ifc.retire_valid); end
    checks++; if (ifc.redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_redirect_valid got %0h exp 0", ifc.redirect_valid); end
    checks++; if (ifc.redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect_pc got %h exp 0", ifc.redirect_pc); end
    checks++; if (ifc.retire_pc !== 32'h0) begin errors++; $display("FAIL rst_retire_pc got %h exp 0", ifc.retire_pc); end
    checks++; if (ifc.minstret !== 64'h0) begin errors++; $display("FAIL rst_minstret got %0d exp 0", ifc.minstret); end
    checks++; if (ifc.dz_flag !== 1'b0) begin errors++; $display("FAIL rst_dz got %0h exp 0", ifc.dz_flag); end
    checks++; if (ifc.rs1_data !== 32'h0) begin errors++; $display("FAIL rst_rf_x5 got %h exp 0", ifc.rs1_data); end
  endtask

  task automatic test_writeback();
    drive(32'h00700293, 32'h40, 32'd7, 1'b0);       // addi x5,x0,7
    ifc.rs1_addr = 5'd5; ifc.rs2_addr = 5'd0;
    #1;
    checks++; if (ifc.rs1_data !== 32'd7) begin errors++; $display("FAIL wb_bypass got %h exp 7", ifc.rs1_data); end
    checks++; if (ifc.rs2_data !== 32'd0) begin errors++; $display("FAIL wb_rs2_x0 got %h exp 0", ifc.rs2_data); end
    tick(); exp_ret++;
    drive(32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    checks++; if (ifc.retire_valid !== 1'b1) begin errors++; $display("FAIL wb_retire_valid got %0h exp 1", ifc.retire_valid); end
    checks++; if (ifc.retire_pc !== 32'h40) begin errors++; $display("FAIL wb_retire_pc got %h exp 40", ifc.retire_pc); end
    checks++; if (ifc.minstret !== exp_ret) begin errors++; $display("FAIL wb_minstret got %0d exp %0d", ifc.minstret, exp_ret); end
    checks++; if (ifc.rs1_data !== 32'd7) begin errors++; $display("FAIL wb_rf_x5 got %h exp 7", ifc.rs1_data); end
    drive(32'h00900013, 32'h44, 32'd9, 1'b0);       // addi x0,x0,9
    ifc.rs1_addr = 5'd0;
    #1;
    checks++; if (ifc.rs1_data !== 32'd0) begin errors++; $display("FAIL wb_x0_bypass got %h exp 0", ifc.rs1_data); end
    tick(); exp_ret++;
    drive(32'h005022A3, 32'h48, 32'hDEAD, 1'b0);    // sw x5,5(x0): rd field = 5
    ifc.rs1_addr = 5'd5;
    #1;
    checks++; if (ifc.rs1_data !== 32'd7) begin errors++; $display("FAIL wb_store_bypass got %h exp 7", ifc.rs1_data); end
    tick(); exp_ret++;
    drive(32'h0, 32'h0, 32'h0, 1'b0);
    ifc.rs2_addr = 5'd0;
    #1;
    checks++; if (ifc.rs1_data !== 32'd7) begin errors++; $display("FAIL wb_store_nowrite got %h exp 7", ifc.rs1_data); end
    checks++; if (ifc.minstret !== exp_ret) begin errors++; $display("FAIL wb_minstret3 got %0d exp %0d", ifc.minstret, exp_ret); end
  endtask

  task automatic test_branch();
    drive(32'hFE209CE3, 32'h100, 32'h0, 1'b0);      // bne x1,x2,-8
    flags(1'b1, 1'b0, 1'b0);
    ifc.rs1_addr = 5'd25;                           // rd field of the bne
    #1;
    checks++; if (ifc.rs1_data !== 32'd0) begin errors++; $display("FAIL br_no_bypass got %h exp 0", ifc.rs1_data); end
    tick(); exp_ret++;
    drive(32'h0, 32'h0, 32'h0, 1'b0); flags(1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (ifc.redirect_valid !== 1'b1) begin errors++; $display("FAIL br_redirect_valid got %0h exp 1", ifc.redirect_valid); end
    checks++; if (ifc.redirect_pc !== 32'hF8) begin errors++; $display("FAIL br_redirect_pc got %h exp f8", ifc.redirect_pc); end
    checks++; if (ifc.retire_pc !== 32'h100) begin errors++; $display("FAIL br_retire_pc got %h exp 100", ifc.retire_pc); end
    tick();
    checks++; if (ifc.redirect_valid !== 1'b0) begin errors++; $display("FAIL br_pulse_end got %0h exp 0", ifc.redirect_valid); end
    checks++; if (ifc.redirect_pc !== 32'hF8) begin errors++; $display("FAIL br_pc_hold got %h exp f8", ifc.redirect_pc); end
    drive(32'hFE209CE3, 32'h200, 32'h0, 1'b0);      // bne, not taken
    tick(); exp_ret++;
    drive(32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    checks++; if (ifc.redirect_valid !== 1'b0) begin errors++; $display("FAIL bnt_redirect got %0h exp 0", ifc.redirect_valid); end
    checks++; if (ifc.retire_valid !== 1'b1) begin errors++; $display("FAIL bnt_retire got %0h exp 1", ifc.retire_valid); end
    checks++; if (ifc.retire_pc !== 32'h200) begin errors++; $display("FAIL bnt_retire_pc got %h exp 200", ifc.retire_pc); end
    checks++; if (ifc.rs1_data !== 32'd0) begin errors++; $display("FAIL br_nowrite got %h exp 0", ifc.rs1_data); end
    drive(32'h010000EF, 32'h300, 32'h304, 1'b0);    // jal x1,+16
    tick(); exp_ret++;
    drive(32'h0, 32'h0, 32'h0, 1'b0);
    ifc.rs1_addr = 5'd1;
    #1;
    checks++; if (ifc.redirect_valid !== 1'b1) begin errors++; $display("FAIL jal_redirect got %0h exp 1", ifc.redirect_valid); end
    checks++; if (ifc.redirect_pc !== 32'h310) begin errors++; $display("FAIL jal_target got %h exp 310", ifc.redirect_pc); end
    checks++; if (ifc.rs1_data !== 32'h304) begin errors++; $display("FAIL jal_link got %h exp 304", ifc.rs1_data); end
    drive(32'h00008067, 32'h310, 32'h314, 1'b0);    // jalr x0,0(x1)
    tick(); exp_ret++;
    drive(32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    checks++; if (ifc.redirect_valid !== 1'b0) begin errors++; $display("FAIL jalr_redirect got %0h exp 0", ifc.redirect_valid); end
    checks++; if (ifc.retire_pc !== 32'h310) begin errors++; $display("FAIL jalr_retire_pc got %h exp 310", ifc.retire_pc); end
    drive(32'h0020C463, 32'h400, 32'h0, 1'b0);      // blt x1,x2,+8
    flags(1'b1, 1'b1, 1'b0);
    tick(); exp_ret++;
    drive(32'h0, 32'h0, 32'h0, 1'b0); flags(1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (ifc.redirect_pc !== 32'h408) begin errors++; $display("FAIL blt_target got %h exp 408", ifc.redirect_pc); end
  endtask

  task automatic test_stall();
    drive(32'h00300313, 32'h500, 32'd3, 1'b1);      // addi x6,x0,3 held
    ifc.rs1_addr = 5'd6;
    #1;
    checks++; if (ifc.rs1_data !== 32'd0) begin errors++; $display("FAIL stall_no_bypass got %h exp 0", ifc.rs1_data); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ifc.retire_valid !== 1'b0 || ifc.minstret !== exp_ret || ifc.rs1_data !== 32'd0) begin
        errors++; $display("FAIL stall_hold%0d got rv=%0h cnt=%0d x6=%h exp rv=0 cnt=%0d x6=0", i, ifc.retire_valid, ifc.minstret, ifc.rs1_data, exp_ret);
      end
    end
    ifc.wb_stall = 1'b0;
    tick(); exp_ret++;
    checks++; if (ifc.minstret !== exp_ret || ifc.retire_valid !== 1'b1) begin errors++; $display("FAIL stall_release got cnt=%0d rv=%0h exp cnt=%0d rv=1", ifc.minstret, ifc.retire_valid, exp_ret); end
    tick(); exp_ret++;                              // same inst again: distinct retire
    drive(32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    checks++; if (ifc.minstret !== exp_ret) begin errors++; $display("FAIL b2b_count got %0d exp %0d", ifc.minstret, exp_ret); end
    checks++; if (ifc.rs1_data !== 32'd3) begin errors++; $display("FAIL stall_rf_x6 got %h exp 3", ifc.rs1_data); end
    tick();
    checks++; if (ifc.retire_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop got %0h exp 0", ifc.retire_valid); end
  endtask

  task automatic test_dz();
    drive(32'h0220C1B3, 32'h600, 32'hFFFFFFFF, 1'b0); // div x3,x1,x2
    flags(1'b0, 1'b0, 1'b1);
    tick(); exp_ret++;
    drive(32'h0, 32'h0, 32'h0, 1'b0); flags(1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (ifc.dz_flag !== 1'b1) begin errors++; $display("FAIL dz_set got %0h exp 1", ifc.dz_flag); end
    tick();
    checks++; if (ifc.dz_flag !== 1'b1) begin errors++; $display("FAIL dz_sticky got %0h exp 1", ifc.dz_flag); end
    ifc.dz_clr = 1'b1;
    tick();
    ifc.dz_clr = 1'b0;
    checks++; if (ifc.dz_flag !== 1'b0) begin errors++; $display("FAIL dz_clear got %0h exp 0", ifc.dz_flag); end
    drive(32'h022081B3, 32'h604, 32'h0, 1'b0);      // mul x3,x1,x2
    flags(1'b0, 1'b0, 1'b1);
    tick(); exp_ret++;
    checks++; if (ifc.dz_flag !== 1'b0) begin errors++; $display("FAIL dz_mul got %0h exp 0", ifc.dz_flag); end
    drive(32'h0220C1B3, 32'h608, 32'h0, 1'b0);      // div with clear same cycle
    ifc.dz_clr = 1'b1;
    tick(); exp_ret++;
    drive(32'h0, 32'h0, 32'h0, 1'b0); flags(1'b0, 1'b0, 1'b0);
    ifc.dz_clr = 1'b0;
    #1;
    checks++; if (ifc.dz_flag !== 1'b1) begin errors++; $display("FAIL dz_set_wins got %0h exp 1", ifc.dz_flag); end
  endtask

  task automatic test_reset_mid();
    drive(32'h05500393, 32'h700, 32'h55, 1'b0);     // addi x7,x0,0x55
    ifc.rs1_addr = 5'd7; ifc.rs2_addr = 5'd6;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (ifc.retire_valid !== 1'b0 || ifc.redirect_valid !== 1'b0 || ifc.dz_flag !== 1'b0) begin
      errors++; $display("FAIL rstm_flags got rv=%0h rd=%0h dz=%0h exp 0", ifc.retire_valid, ifc.redirect_valid, ifc.dz_flag);
    end
    checks++; if (ifc.redirect_pc !== 32'h0 || ifc.retire_pc !== 32'h0) begin errors++; $display("FAIL rstm_pcs got %h %h exp 0", ifc.redirect_pc, ifc.retire_pc); end
    checks++; if (ifc.minstret !== 64'h0) begin errors++; $display("FAIL rstm_minstret got %0d exp 0", ifc.minstret); end
    checks++; if (ifc.rs2_data !== 32'h0) begin errors++; $display("FAIL rstm_rf_x6 got %h exp 0", ifc.rs2_data); end
    tick();
    drive(32'h0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    exp_ret = 0;
    #1;
    checks++; if (ifc.rs1_data !== 32'h0) begin errors++; $display("FAIL rstm_no_write got %h exp 0", ifc.rs1_data); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16 && (exp_ret % 16) != 15; i++) begin
      drive(32'h00100413, 32'h800, 32'd1, 1'b0);    // addi x8,x0,1
      tick(); exp_ret++;
    end
    drive(32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    checks++; if (ifc_w.minstret !== 4'hF) begin errors++; $display("FAIL wrap_pre got %0d exp 15", ifc_w.minstret); end
    drive(32'h00100413, 32'h804, 32'd1, 1'b0);
    tick(); exp_ret++;
    drive(32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    checks++; if (ifc_w.minstret !== 4'h0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", ifc_w.minstret); end
    checks++; if (ifc.minstret !== 64'd16) begin errors++; $display("FAIL wrap_wide got %0d exp 16", ifc.minstret); end
  endtask

  initial begin
    test_reset();
    test_writeback();
    test_branch();
    test_stall();
    test_dz();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
